// File: rtl/esp32_rom_loader.sv
// rtl/esp32_rom_loader.sv - ESP32 SPI byte writes to SDRAM word writes plus game configuration
module esp32_rom_loader #(
   parameter int FIFO_DEPTH = 8,
   parameter int WAIT_MIN   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_wr,
   input  logic [31:0] spi_addr,
   input  logic [7:0]  spi_data,
   input  logic        ram_busy,
   output logic        ram_wr,
   output logic [24:0] ram_addr,
   output logic [15:0] ram_din,
   output logic        load_done,
   output logic [7:0]  rom_type,
   output logic [23:0] rom_mask,
   output logic [23:0] ram_mask,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(WAIT_MIN + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} ctrl_state_t;
   typedef enum logic {WIDLE, WAIT} wr_state_t;

   ctrl_state_t   cstate, cnext;
   wr_state_t     wstate, wnext;

   logic          spi_wr_q, spi_wr_qq, ev;
   logic          rom_sel, even_wr, push, push_ok, pop;
   logic          start_ev, finish_ev, cfg_type, cfg_ram, latch_mask;
   logic          active, fifo_empty, fifo_full;
   logic [38:0]   fifo_mem [FIFO_DEPTH];
   logic [38:0]   head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [CW-1:0] wcnt;
   logic [7:0]    lo_byte;
   logic [23:0]   hi_addr, smear, rom_mask_new, ram_mask_new;
   logic [31:0]   ram_shift;

   assign ev         = spi_wr_q & ~spi_wr_qq;
   assign rom_sel    = ev && (spi_addr[31:24] == 8'h00) && (cstate == LOAD);
   assign even_wr    = rom_sel && !spi_addr[0];
   assign push       = rom_sel && spi_addr[0];
   assign cfg_type   = ev && (spi_addr == 32'hFE00_0000);
   assign cfg_ram    = ev && (spi_addr == 32'hFE00_0001);
   assign start_ev   = ev && (spi_addr == 32'hFE00_0002);
   assign finish_ev  = ev && (spi_addr == 32'hFE00_0003);
   assign active     = (cstate == LOAD) || (cstate == DRAIN);
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
   assign push_ok    = push && (!fifo_full || pop);
   assign head       = fifo_mem[rd_ptr];
   assign load_done  = (cstate == DONE);

   // Two-stage history of spi_wr; ev is high for the cycle after each rising edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spi_wr_q  <= 1'b0;
         spi_wr_qq <= 1'b0;
      end else begin
         spi_wr_q  <= spi_wr;
         spi_wr_qq <= spi_wr_q;
      end
   end

   // Control and write state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cstate <= IDLE;
         wstate <= WIDLE;
      end else begin
         cstate <= cnext;
         wstate <= wnext;
      end
   end

   // Control FSM: start always wins; DRAIN finishes once the FIFO and the write FSM are idle
   always_comb begin
      cnext      = cstate;
      latch_mask = 1'b0;
      if (start_ev) begin
         cnext = LOAD;
      end else begin
         case (cstate)
            LOAD:    if (finish_ev) cnext = DRAIN;
            DRAIN:   if (fifo_empty && (wstate == WIDLE)) begin
                        cnext      = DONE;
                        latch_mask = 1'b1;
                     end
            default: cnext = cstate;
         endcase
      end
   end

   // Write FSM: issue one word when idle and not busy, then hold off WAIT_MIN cycles and until busy drops
   always_comb begin
      wnext = wstate;
      pop   = 1'b0;
      case (wstate)
         WIDLE:   if (active && !fifo_empty && !ram_busy && !start_ev) begin
                     pop   = 1'b1;
                     wnext = WAIT;
                  end
         WAIT:    if ((wcnt >= CW'(WAIT_MIN - 1)) && !ram_busy) wnext = WIDLE;
         default: wnext = WIDLE;
      endcase
   end

   // Registered write strobe and held address/data; WAIT cycle counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_wr   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         wcnt     <= '0;
      end else begin
         ram_wr <= pop;
         if (pop) begin
            ram_addr <= {1'b0, head[38:16], 1'b0};
            ram_din  <= head[15:0];
         end
         if (wstate == WIDLE) wcnt <= '0;
         else if (wcnt < CW'(WAIT_MIN - 1)) wcnt <= wcnt + CW'(1);
      end
   end

   // FIFO storage; entries are {word address, odd byte, even byte}
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= {spi_addr[23:1], spi_data, lo_byte};
   end

   // FIFO pointers and occupancy; start flushes everything queued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (start_ev) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // BSRAM mask from size code, and ROM mask as the bit-smear of the highest byte address
   always_comb begin
      ram_shift    = (32'h400 << spi_data[3:0]) - 32'd1;
      ram_mask_new = (spi_data[3:0] == 4'd0)   ? 24'h0 :
                     (ram_shift > 32'hFF_FFFF) ? 24'hFF_FFFF : ram_shift[23:0];
      smear        = hi_addr;
      smear        = smear | (smear >> 1);
      smear        = smear | (smear >> 2);
      smear        = smear | (smear >> 4);
      smear        = smear | (smear >> 8);
      smear        = smear | (smear >> 16);
      rom_mask_new = smear | 24'h00_7FFF;
   end

   // Configuration registers, pending even byte, highest address seen and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rom_type <= '0;
         ram_mask <= '0;
         rom_mask <= '0;
         lo_byte  <= '0;
         hi_addr  <= '0;
         overflow <= 1'b0;
      end else begin
         if (cfg_type)   rom_type <= spi_data;
         if (cfg_ram)    ram_mask <= ram_mask_new;
         if (even_wr)    lo_byte  <= spi_data;
         if (latch_mask) rom_mask <= rom_mask_new;
         if (start_ev) begin
            hi_addr  <= '0;
            overflow <= 1'b0;
         end else begin
            if (push && (spi_addr[23:0] > hi_addr)) hi_addr <= spi_addr[23:0];
            if (push && fifo_full && !pop)          overflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_esp32_rom_loader.sv
// tb/tb_esp32_rom_loader.sv - scoreboard bench for esp32_rom_loader
module tb_esp32_rom_loader;
   localparam int FIFO_DEPTH = 8;
   localparam int WAIT_MIN   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_wr;
   logic [31:0] spi_addr;
   logic [7:0]  spi_data;
   logic        ram_busy;
   logic        ram_wr;
   logic [24:0] ram_addr;
   logic [15:0] ram_din;
   logic        load_done;
   logic [7:0]  rom_type;
   logic [23:0] rom_mask;
   logic [23:0] ram_mask;
   logic        overflow;

   logic busy_hold = 1'b0;
   logic busy_rand = 1'b0;
   logic busy_rand_en = 1'b0;
   assign ram_busy = busy_hold | busy_rand;

   esp32_rom_loader #(.FIFO_DEPTH(FIFO_DEPTH), .WAIT_MIN(WAIT_MIN)) dut (
      .clk(clk), .reset(reset), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_data(spi_data),
      .ram_busy(ram_busy), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
      .load_done(load_done), .rom_type(rom_type), .rom_mask(rom_mask), .ram_mask(ram_mask),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic [40:0] exp_q[$];
   int          m_state;     // 0 idle, 1 load, 2 drain, 3 done
   logic [7:0]  m_lo, m_type;
   logic [23:0] m_hi, m_ram;
   bit          m_ovf;
   int          held_cnt;

   // Monitor bookkeeping
   logic [40:0] mon_e;
   int          last_wr_cyc = -100;
   int          last_odd_cyc = 0;
   int          ev_cyc = 0;
   int          wr_count = 0;
   int          done_rise_cyc = 0;
   logic [15:0] last_din = '0;
   logic        prev_ld = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_min(input string name, input int act, input int lim);
      total++;
      if (act < lim) begin
         bad++;
         $display("FAIL %s: got %0d want >= %0d", name, act, lim);
      end
   endtask

   function automatic logic [23:0] ram_mask_of(input logic [3:0] k);
      longint v;
      if (k == 4'd0) return 24'h0;
      v = (longint'(1) << (10 + int'(k))) - 1;
      if (v > 64'hFF_FFFF) v = 64'hFF_FFFF;
      return v[23:0];
   endfunction

   function automatic logic [23:0] rom_mask_of(input logic [23:0] h);
      longint m;
      m = 64'h7FFF;
      while (m < longint'(h)) m = m * 2 + 1;
      return m[23:0];
   endfunction

   task automatic model_reset();
      m_state = 0; m_lo = '0; m_type = '0; m_hi = '0; m_ram = '0; m_ovf = 0; held_cnt = 0;
   endtask

   task automatic model_byte(input logic [31:0] a, input logic [7:0] d);
      if (a[31:24] == 8'h00) begin
         if (m_state == 1) begin
            if (!a[0]) m_lo = d;
            else begin
               if (a[23:0] > m_hi) m_hi = a[23:0];
               if (busy_hold && held_cnt >= FIFO_DEPTH) m_ovf = 1;
               else begin
                  exp_q.push_back({1'b0, a[23:1], 1'b0, d, m_lo});
                  if (busy_hold) held_cnt++;
               end
            end
         end
      end else if (a == 32'hFE00_0000) m_type = d;
      else if (a == 32'hFE00_0001) m_ram = ram_mask_of(d[3:0]);
      else if (a == 32'hFE00_0002) begin
         m_state = 1; m_hi = '0; m_ovf = 0; held_cnt = 0;
      end else if (a == 32'hFE00_0003) begin
         if (m_state == 1) m_state = 2;
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [7:0] d, input int gap);
      model_byte(a, d);
      spi_addr = a;
      spi_data = d;
      @(negedge clk);
      spi_wr = 1'b1;
      @(negedge clk);
      ev_cyc = cyc;
      @(negedge clk);
      spi_wr = 1'b0;
      repeat (gap) @(negedge clk);
      if (a[31:24] == 8'h00 && a[0]) last_odd_cyc = ev_cyc;
   endtask

   task automatic wait_q(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!load_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, load_done, 1);
      if (load_done) m_state = 3;
   endtask

   // Scoreboard monitor: every ram_wr pops the oldest expected word
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (load_done && !prev_ld) done_rise_cyc = cyc;
            prev_ld = load_done;
            if (ram_wr) begin
               check("wr_outside_load", load_done, 0);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_wr: got addr %0h din %0h want none", ram_addr, ram_din);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("wr_addr", ram_addr, mon_e[40:16]);
                  check("wr_din", ram_din, mon_e[15:0]);
               end
               check_min("wr_spacing", cyc - last_wr_cyc, WAIT_MIN + 1);
               last_wr_cyc = cyc;
               last_din = ram_din;
               wr_count++;
            end
         end else begin
            prev_ld = 1'b0;
         end
      end
   end

   // SDRAM controller stand-in: random busy time after each write
   initial begin
      int n;
      forever begin
         @(negedge clk);
         if (busy_rand_en && ram_wr && !reset) begin
            n = $urandom_range(0, 2);
            busy_rand = 1'b1;
            repeat (n) @(negedge clk);
            busy_rand = 1'b0;
         end
      end
   end

   initial begin
      int base;
      logic [23:0] a24, amask;
      int op;
      reset = 1'b1; spi_wr = 1'b0; spi_addr = '0; spi_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_ram_wr", ram_wr, 0);
      check("rst_load_done", load_done, 0);
      check("rst_rom_mask", rom_mask, 0);
      check("rst_ram_mask", ram_mask, 0);
      check("rst_overflow", overflow, 0);
      reset = 1'b0;
      @(negedge clk);

      // Single word, latency from odd event
      send(32'hFE00_0002, 8'h00, 3);
      send(32'h0000_0000, 8'h34, 3);
      send(32'h0000_0001, 8'h12, 6);
      wait_q("t2_drain");
      check("t2_latency", last_wr_cyc - last_odd_cyc, 2);
      check("t2_din", last_din, 16'h1234);

      // Busy held: FIFO fills, overflow, then exactly FIFO_DEPTH writes
      busy_hold = 1'b1;
      send(32'hFE00_0002, 8'h00, 2);
      for (int i = 0; i < 10; i++) begin
         send(32'(2 * i), 8'($urandom), 2);
         send(32'(2 * i + 1), 8'($urandom), 2);
      end
      check("t3_overflow", overflow, 1);
      check("t3_overflow_model", overflow, m_ovf);
      base = wr_count;
      busy_hold = 1'b0;
      wait_q("t3_drain");
      repeat (20) @(negedge clk);
      check("t3_wr_count", wr_count - base, FIFO_DEPTH);
      send(32'hFE00_0003, 8'h00, 2);
      wait_done("t3_done");
      check("t3_rom_mask", rom_mask, 24'h00_7FFF);

      // Restart from DONE; foreign address space ignored
      model_byte(32'hFE00_0002, 8'h00);
      spi_addr = 32'hFE00_0002;
      @(negedge clk);
      spi_wr = 1'b1;
      @(negedge clk);
      check("t6_done_before", load_done, 1);
      @(negedge clk);
      check("t6_done_cleared", load_done, 0);
      check("t6_ovf_cleared", overflow, 0);
      spi_wr = 1'b0;
      repeat (3) @(negedge clk);
      send(32'h0700_0010, 8'hAA, 2);
      send(32'h0700_0011, 8'hBB, 2);
      send(32'h0000_0020, 8'h5A, 2);
      send(32'h0000_0021, 8'hA5, 2);
      send(32'hFE00_0003, 8'h00, 2);
      wait_done("t6_done");
      check("t6_queue_empty", exp_q.size(), 0);
      check("t6_rom_mask", rom_mask, 24'h00_7FFF);

      // Configuration bytes
      send(32'hFE00_0000, 8'h01, 2);
      send(32'hFE00_0001, 8'h01, 2);
      check("t5_rom_type", rom_type, 8'h01);
      check("t5_ram_mask", ram_mask, 24'h00_07FF);
      for (int i = 0; i < 6; i++) begin
         op = (i < 4) ? ((i == 0) ? 0 : 12 + i) : int'($urandom_range(0, 15));
         send(32'hFE00_0001, {4'($urandom), 4'(op)}, 2);
         check("t5_ram_mask_k", ram_mask, m_ram);
      end
      send(32'hFE00_0001, 8'h05, 2);
      send(32'hFE00_0002, 8'h00, 2);
      send(32'h0000_0100, 8'h11, 2);
      send(32'h0000_0101, 8'h22, 2);
      send(32'hFE00_0003, 8'h00, 2);
      wait_done("t5_done");
      check("t5_rom_mask", rom_mask, 24'h00_7FFF);

      // Larger image with random busy, top byte 0x5FFFF
      busy_rand_en = 1'b1;
      send(32'hFE00_0002, 8'h00, 2);
      for (int i = 0; i < 20; i++) begin
         a24 = 24'($urandom_range(0, 32'h5FFF0)) & 24'hFF_FFFE;
         send({8'h00, a24}, 8'($urandom), 2);
         send({8'h00, a24 | 24'h1}, 8'($urandom), 2);
      end
      send(32'h0005_FFFE, 8'hC3, 2);
      send(32'h0005_FFFF, 8'h3C, 2);
      send(32'hFE00_0003, 8'h00, 2);
      wait_done("t4_done");
      check("t4_rom_mask", rom_mask, 24'h07_FFFF);
      check_min("t4_done_after_wait", done_rise_cyc - last_wr_cyc, WAIT_MIN + 1);
      check("t4_queue_empty", exp_q.size(), 0);

      // Randomised loads mixing ROM bytes, stale even bytes, config and foreign writes
      for (int r = 0; r < 4; r++) begin
         send(32'hFE00_0002, 8'h00, 3);
         case ($urandom_range(0, 2))
            0:       amask = 24'h00_FFFF;
            1:       amask = 24'h0F_FFFF;
            default: amask = 24'hFF_FFFF;
         endcase
         for (int i = 0; i < 30; i++) begin
            op  = int'($urandom_range(0, 7));
            a24 = 24'($urandom) & amask;
            if (op < 3)      send({8'h00, a24 & 24'hFF_FFFE}, 8'($urandom), $urandom_range(3, 5));
            else if (op < 6) send({8'h00, a24 | 24'h1}, 8'($urandom), $urandom_range(3, 5));
            else if (op == 6) send(32'hFE00_0000, 8'($urandom), $urandom_range(3, 5));
            else send({8'($urandom_range(1, 253)), a24}, 8'($urandom), $urandom_range(3, 5));
         end
         send(32'hFE00_0003, 8'h00, 2);
         wait_done("rnd_done");
         check("rnd_rom_mask", rom_mask, rom_mask_of(m_hi));
         check("rnd_rom_type", rom_type, m_type);
         check("rnd_queue_empty", exp_q.size(), 0);
      end
      busy_rand_en = 1'b0;
      repeat (5) @(negedge clk);

      // Asynchronous reset while draining with words still queued
      busy_hold = 1'b1;
      send(32'hFE00_0002, 8'h00, 2);
      for (int i = 0; i < 3; i++) begin
         send(32'(2 * i), 8'($urandom), 2);
         send(32'(2 * i + 1), 8'($urandom), 2);
      end
      send(32'hFE00_0003, 8'h00, 2);
      check("t1_drain_not_done", load_done, 0);
      #2 reset = 1'b1;
      #1;
      check("t1_ram_wr", ram_wr, 0);
      check("t1_load_done", load_done, 0);
      check("t1_rom_mask", rom_mask, 0);
      check("t1_ram_mask", ram_mask, 0);
      check("t1_rom_type", rom_type, 0);
      check("t1_overflow", overflow, 0);
      exp_q.delete();
      model_reset();
      busy_hold = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("t1_idle_after_reset", load_done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
